// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce_pkg
// Purpose : Shared constants for the push-button debouncer: FSM state
//           encoding and default parameter values.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package key_debounce_pkg;

    // 20 ms of stable input at a 50 MHz system clock.
    localparam int DEFAULT_STABLE_CNT = 1000000;
    localparam int DEFAULT_CNT_W      = 20;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

endpackage : key_debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Purpose : Two-flop synchronizer for a single asynchronous board input.
// Ports   : clk   - system clock, rising edge
//           rst   - synchronous active-low reset (0 = reset)
//           d_in  - asynchronous input level
//           q_out - synchronized level (second flop)
// Revision: 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);

    logic stage1_d;
    logic stage1_q;
    logic stage2_d;
    logic stage2_q;

    always_comb begin
        stage1_d = d_in;
        stage2_d = stage1_q;
    end

    // The first stage may go metastable; only the second stage is used.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stage1_q <= 1'b0;
            stage2_q <= 1'b0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign q_out = stage2_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce
// Purpose : Debounces a bouncy active-high push-button. A level change is
//           accepted only after STABLE_CNT consecutive synchronized samples
//           at the new level; one-cycle press/release pulses mark each
//           accepted change.
// Ports   : clk         - system clock, rising edge
//           rst         - synchronous active-low reset (0 = reset)
//           key_in      - raw asynchronous button level
//           key_out     - debounced level (registered)
//           key_press   - one-cycle pulse on key_out 0->1 (registered)
//           key_release - one-cycle pulse on key_out 1->0 (registered)
// Revision: 1.0 - initial release
// ============================================================================
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int STABLE_CNT = DEFAULT_STABLE_CNT,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic             key_s;

    state_t           state_d;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             key_out_d;
    logic             key_out_q;
    logic             key_press_d;
    logic             key_press_q;
    logic             key_release_d;
    logic             key_release_q;

    sync_2ff u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (key_in),
        .q_out (key_s)
    );

    // The first sample at the new level enters the wait state with cnt=1, so
    // reaching C_CNT_LAST while still at the new level means STABLE_CNT
    // consecutive samples have been seen. cnt is cleared on every exit from
    // a wait state, so it can never pass C_CNT_LAST.
    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;

        case (state_q)
            ST_LOW: begin
                if (key_s) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = C_CNT_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                if (!key_s) begin
                    state_d = ST_LOW;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d     = ST_HIGH;
                    key_press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!key_s) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = C_CNT_ONE;
                end
            end
            ST_WAIT_LOW: begin
                if (key_s) begin
                    state_d = ST_HIGH;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d       = ST_LOW;
                    key_release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
            end
        endcase

        // Debounced level is high while the accepted level is high, including
        // while a candidate release is still being qualified.
        key_out_d = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_LOW;
            cnt_q         <= '0;
            key_out_q     <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_out_q     <= key_out_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_out     = key_out_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;

endmodule : key_debounce
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_debounce
// Purpose : Self-checking bench for key_debounce (STABLE_CNT=4, CNT_W=3).
//           A run-length reference model predicts the outputs after every
//           clock edge; a monitor compares them one cycle at a time.
// Revision: 1.0 - initial release
// ============================================================================
module tb_key_debounce;
    import key_debounce_pkg::*;

    localparam int STABLE = 4;
    localparam int CW     = 3;

    logic clk = 1'b0;
    logic rst;
    logic key_in;
    logic key_out;
    logic key_press;
    logic key_release;

    int checks = 0;
    int passes = 0;
    int press_cnt = 0;
    int release_cnt = 0;

    typedef struct packed {
        logic o;
        logic p;
        logic r;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    key_debounce #(
        .STABLE_CNT (STABLE),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    // Reference model: the input reaches the decision logic two edges late;
    // the accepted level flips once STABLE consecutive samples disagree with it.
    initial begin : model
        logic s0, s1, ks, lvl, p, r;
        int   run;
        s0 = 1'b0; s1 = 1'b0; lvl = 1'b0; run = 0;
        forever begin
            @(posedge clk);
            p = 1'b0;
            r = 1'b0;
            if (!rst) begin
                s0 = 1'b0; s1 = 1'b0; lvl = 1'b0; run = 0;
            end else begin
                ks = s1;
                s1 = s0;
                s0 = key_in;
                if (ks != lvl) begin
                    run++;
                    if (run == STABLE) begin
                        lvl = ks;
                        run = 0;
                        if (ks) p = 1'b1;
                        else    r = 1'b1;
                    end
                end else begin
                    run = 0;
                end
            end
            exp_q.push_back('{o: lvl, p: p, r: r});
        end
    end

    // Monitor: compare the DUT against the oldest prediction each cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (key_press)   press_cnt++;
            if (key_release) release_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_key_out", key_out, e.o);
                check("sb_key_press", key_press, e.p);
                check("sb_key_release", key_release, e.r);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic k, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            key_in = k;
        end
    endtask

    task automatic wait_edges_then_sample(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : stim
        int  p0, r0;
        logic held_ok;
        rst    = 1'b0;
        key_in = 1'b1;

        // Reset held with key high: outputs stay low.
        repeat (3) @(negedge clk);
        check("rst_key_out", key_out, 1'b0);
        check("rst_key_press", key_press, 1'b0);
        check("rst_key_release", key_release, 1'b0);
        rst = 1'b1;
        wait_edges_then_sample(6);
        check("rst_rel_key_out", key_out, 1'b1);
        check("rst_rel_key_press", key_press, 1'b1);
        @(negedge clk);
        check("rst_rel_press_drop", key_press, 1'b0);

        // Clean release and clean press.
        key_in = 1'b0;
        wait_edges_then_sample(6);
        check("clean_rel_key_out", key_out, 1'b0);
        check("clean_rel_pulse", key_release, 1'b1);
        drive(1'b0, 5);
        key_in = 1'b1;
        wait_edges_then_sample(6);
        check("clean_press_key_out", key_out, 1'b1);
        check("clean_press_pulse", key_press, 1'b1);
        drive(1'b1, 6);

        // Glitch low while held: no release.
        r0 = release_cnt;
        drive(1'b0, 3);
        drive(1'b1, 10);
        check("glitch_key_out", key_out, 1'b1);
        check_int("glitch_no_release", release_cnt - r0, 0);

        // Return low, then bouncy press.
        drive(1'b0, 12);
        p0 = press_cnt;
        drive(1'b1, 3);
        drive(1'b0, 1);
        drive(1'b1, 2);
        drive(1'b0, 1);
        check("bounce_key_out", key_out, 1'b0);
        check_int("bounce_no_press", press_cnt - p0, 0);
        @(negedge clk);
        key_in = 1'b1;
        wait_edges_then_sample(6);
        check("bounce_key_out_rise", key_out, 1'b1);
        check("bounce_press_pulse", key_press, 1'b1);
        drive(1'b1, 5);
        check_int("bounce_one_press", press_cnt - p0, 1);

        // Reset while qualifying a press.
        drive(1'b0, 12);
        key_in = 1'b1;
        wait_edges_then_sample(4);
        check_int("midwait_cnt_before", int'(dut.cnt_q), 2);
        r0 = release_cnt;
        p0 = press_cnt;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("midwait_state_low", dut.state_q == ST_LOW, 1'b1);
        check_int("midwait_cnt_zero", int'(dut.cnt_q), 0);
        check("midwait_key_out", key_out, 1'b0);
        wait_edges_then_sample(6);
        check("midwait_press_pulse", key_press, 1'b1);
        check_int("midwait_no_release", release_cnt - r0, 0);
        check_int("midwait_one_press", press_cnt - p0, 1);

        // Long hold: exactly one press pulse, level continuously high.
        drive(1'b0, 12);
        p0 = press_cnt;
        key_in = 1'b1;
        wait_edges_then_sample(6);
        held_ok = 1'b1;
        for (int i = 0; i < 94; i++) begin
            @(negedge clk);
            if (key_out !== 1'b1) held_ok = 1'b0;
        end
        check("hold_key_out_steady", held_ok, 1'b1);
        check_int("hold_one_press", press_cnt - p0, 1);

        // Randomized bursts with occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 29) == 0) begin
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
        end

        drive(1'b0, 10);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_key_debounce
`default_nettype wire

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The module SHALL have parameter STABLE_CNT, default 1000000, meaning consecutive stable synchronized samples required to accept a level change (20 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
REQ-002 The module SHALL have parameter CNT_W, default 20, meaning stability counter width.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-005 key_in  input  1  raw asynchronous push-button level, bouncy, active-high.
REQ-006 key_out  output  1  debounced level; drives sel_in of the downstream single-pulse selector.
REQ-007 key_press  output  1  one-cycle pulse when key_out goes 0->1.
REQ-008 key_release  output  1  one-cycle pulse when key_out goes 1->0.

Function
REQ-009 key_in SHALL pass through a two-flop synchronizer; key_s denotes the second flop output; no other logic SHALL sample key_in.
REQ-010 FSM states SHALL be LOW, WAIT_HIGH, HIGH, WAIT_LOW; key_out SHALL be 1 exactly in HIGH and WAIT_LOW.
REQ-011 LOW: key_s=1 -> WAIT_HIGH with cnt<=1; else stay, cnt<=0.
REQ-012 WAIT_HIGH: key_s=0 -> LOW, cnt<=0; key_s=1 and cnt==STABLE_CNT-1 -> HIGH, cnt<=0, key_press<=1; key_s=1 otherwise -> stay, cnt<=cnt+1.
REQ-013 HIGH: key_s=0 -> WAIT_LOW with cnt<=1; else stay, cnt<=0.
REQ-014 WAIT_LOW: key_s=1 -> HIGH, cnt<=0; key_s=0 and cnt==STABLE_CNT-1 -> LOW, cnt<=0, key_release<=1; key_s=0 otherwise -> stay, cnt<=cnt+1.
REQ-015 key_out, key_press, key_release SHALL all be registered outputs; key_press and key_release SHALL be 0 in every cycle other than the transition cycle defined above.
REQ-016 Latency: a clean key_in step settling before rising edge 0 SHALL change key_out after rising edge STABLE_CNT+1 (i.e. visible in cycle STABLE_CNT+2), with the matching pulse in that same cycle.
REQ-017 Any key_s excursion shorter than STABLE_CNT consecutive samples SHALL leave key_out unchanged and produce no pulse.
REQ-018 cnt SHALL never exceed STABLE_CNT-1 and SHALL never wrap; key_press and key_release SHALL never be 1 in the same cycle.
REQ-019 key_press and key_release SHALL strictly alternate, key_press first after reset.

Reset
REQ-020 While rst=0 at a rising edge: both synchronizer flops <=0, state <=LOW, cnt <=0, key_out, key_press, key_release <=0.
REQ-021 Reset during WAIT_HIGH/HIGH/WAIT_LOW SHALL abort without emitting key_release; if key_in is still high after rst returns to 1, a full debounce (REQ-016 latency counted from the first edge with rst=1) SHALL re-run and emit key_press.

Structure
REQ-022 State encodings (LOW=0, WAIT_HIGH=1, HIGH=2, WAIT_LOW=3) and the default STABLE_CNT SHALL live in the shared project constants include file.
REQ-023 The two-flop synchronizer SHALL be a separate sub-module named sync_2ff, reusable for other asynchronous board inputs.
REQ-024 The FSM SHALL use a registered state plus a combinational next-state block.

Verification (STABLE_CNT=4, CNT_W=3)
REQ-025 Reset: rst=0 for 3 cycles with key_in=1 -> all outputs 0; after rst=1, key_out=1 and key_press=1 in cycle 6, key_press=0 in cycle 7.
REQ-026 Clean press: key_in 0->1 before edge 0, held -> key_out rises in cycle 6, single key_press pulse; release held -> key_out falls 6 cycles later with single key_release pulse.
REQ-027 Bounce: key_in high 3 cycles, low 1, high 2, low 1, then high steady -> no output change during bounce; key_out rises 6 cycles after the final rising edge of key_in, exactly one key_press.
REQ-028 Glitch while held: key_out=1, key_in low for 3 cycles then high -> key_out stays 1, no key_release.
REQ-029 Reset mid-wait: rst=0 for 1 cycle while in WAIT_HIGH (cnt=2) -> state LOW, cnt=0, no pulse; key_in still high -> key_press in cycle 6 after reset release.
REQ-030 Pairing with the downstream selector: press held 100 cycles -> key_out high continuously, selector emits exactly one sel_out pulse.
